// File: rtl/inlier_acc_pkg.sv
// Shared types for the RANSAC inlier accumulator: FSM states, model widths and the model record.
package inlier_acc_pkg;

   localparam int COORD_W = 9;
   localparam int BETA_W  = 17;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SWEEP   = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_COMPARE = 2'd3
   } state_t;

   typedef struct packed {
      logic signed [COORD_W-1:0] deltaX;
      logic signed [COORD_W-1:0] deltaY;
      logic signed [BETA_W-1:0]  beta;
   } model_t;

endpackage

// File: rtl/inlier_accumulator_valid_delay_line.sv
// Shift register of point-valid bits; the tail marks the cycle a point's inlier flag is due.
module valid_delay_line #(
   parameter int DEPTH = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic tail
);

   logic [DEPTH-1:0] sr_reg;
   logic [DEPTH-1:0] sr_next;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign sr_next[gi] = din;
         end else begin : g_body
            assign sr_next[gi] = sr_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) sr_reg <= '0;
      else       sr_reg <= sr_next;
   end

   assign tail = sr_reg[DEPTH-1];

endmodule

// File: rtl/inlier_accumulator.sv
// Counts inlier flags per line hypothesis and keeps the best-scoring model since the last clear.
// Optional consensus detector enabled by defining INLIER_ACC_CONSENSUS_EN.
module inlier_accumulator
   import inlier_acc_pkg::*;
#(
   parameter  int MAX_POINTS = 1023,
   parameter  int PIPE_LAT   = 5,
   localparam int CNT_W      = $clog2(MAX_POINTS + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      hyp_start,
   input  logic signed [COORD_W-1:0] deltaX,
   input  logic signed [COORD_W-1:0] deltaY,
   input  logic signed [BETA_W-1:0]  beta,
   input  logic                      pt_valid,
   input  logic                      pt_last,
   input  logic                      inlier,
   input  logic                      best_clear,
`ifdef INLIER_ACC_CONSENSUS_EN
   input  logic [CNT_W-1:0]          consensus_count,
   output logic                      consensus_met,
`endif
   output logic                      busy,
   output logic                      hyp_done,
   output logic [CNT_W-1:0]          count,
   output logic [CNT_W-1:0]          best_count,
   output logic signed [COORD_W-1:0] best_deltaX,
   output logic signed [COORD_W-1:0] best_deltaY,
   output logic signed [BETA_W-1:0]  best_beta,
   output logic                      best_valid
);

   localparam int DRN_W = $clog2(PIPE_LAT + 1);

   state_t           state_reg;
   logic [CNT_W-1:0] work_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] best_count_reg;
   logic [DRN_W-1:0] drain_reg;
   model_t           model_reg;
   model_t           best_model_reg;
   logic             best_valid_reg;
   logic             push;
   logic             tail;
   logic             sampling;
   logic             record;

   assign push     = pt_valid && (state_reg == ST_SWEEP);
   assign sampling = (state_reg == ST_SWEEP) || (state_reg == ST_DRAIN);
   // A coincident clear empties the record first, so the current hypothesis always lands.
   assign record   = (state_reg == ST_COMPARE) &&
                     (best_clear || !best_valid_reg || (work_reg > best_count_reg));

   valid_delay_line #(.DEPTH(PIPE_LAT)) u_delay (
      .clk   (clk),
      .reset (reset),
      .din   (push),
      .tail  (tail)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         work_reg       <= '0;
         count_reg      <= '0;
         drain_reg      <= '0;
         model_reg      <= '0;
         best_count_reg <= '0;
         best_model_reg <= '0;
         best_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (hyp_start) begin
                  model_reg <= '{deltaX: deltaX, deltaY: deltaY, beta: beta};
                  work_reg  <= '0;
                  state_reg <= ST_SWEEP;
               end
            end
            ST_SWEEP: begin
               if (pt_valid && pt_last) begin
                  drain_reg <= DRN_W'(PIPE_LAT);
                  state_reg <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               drain_reg <= drain_reg - 1'b1;
               if (drain_reg == DRN_W'(1)) state_reg <= ST_COMPARE;
            end
            ST_COMPARE: begin
               count_reg <= work_reg;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase

         if (sampling && tail && inlier && (work_reg != CNT_W'(MAX_POINTS)))
            work_reg <= work_reg + 1'b1;

         if (record) begin
            best_count_reg <= work_reg;
            best_model_reg <= model_reg;
            best_valid_reg <= 1'b1;
         end else if (best_clear) begin
            best_count_reg <= '0;
            best_model_reg <= '0;
            best_valid_reg <= 1'b0;
         end
      end
   end

`ifdef INLIER_ACC_CONSENSUS_EN
   logic consensus_reg;

   always_ff @(posedge clk) begin
      if (reset || best_clear)
         consensus_reg <= 1'b0;
      else if (best_valid_reg && (best_count_reg >= consensus_count))
         consensus_reg <= 1'b1;
   end

   assign consensus_met = consensus_reg;
`endif

   assign busy        = (state_reg != ST_IDLE);
   assign hyp_done    = (state_reg == ST_COMPARE);
   assign count       = count_reg;
   assign best_count  = best_count_reg;
   assign best_deltaX = best_model_reg.deltaX;
   assign best_deltaY = best_model_reg.deltaY;
   assign best_beta   = best_model_reg.beta;
   assign best_valid  = best_valid_reg;

endmodule

// File: tb/tb_inlier_accumulator.sv
// Directed + randomized bench for inlier_accumulator against a point-level reference model.
module tb_inlier_accumulator;

   localparam int PL    = 5;
   localparam int MAXP  = 1023;
   localparam int CNT_W = 10;
   localparam int TL_N  = 1200;

   logic               clk = 1'b0;
   logic               reset, hyp_start, pt_valid, pt_last, inlier, best_clear;
   logic signed [8:0]  deltaX, deltaY, best_deltaX, best_deltaY;
   logic signed [16:0] beta, best_beta;
   logic               busy, hyp_done, best_valid;
   logic [CNT_W-1:0]   count, best_count;
`ifdef INLIER_ACC_CONSENSUS_EN
   logic [CNT_W-1:0]   consensus_count;
   logic               consensus_met;
`endif

   always #5 clk = ~clk;

   inlier_accumulator #(.MAX_POINTS(MAXP), .PIPE_LAT(PL)) dut (
      .clk(clk), .reset(reset), .hyp_start(hyp_start),
      .deltaX(deltaX), .deltaY(deltaY), .beta(beta),
      .pt_valid(pt_valid), .pt_last(pt_last), .inlier(inlier), .best_clear(best_clear),
`ifdef INLIER_ACC_CONSENSUS_EN
      .consensus_count(consensus_count), .consensus_met(consensus_met),
`endif
      .busy(busy), .hyp_done(hyp_done), .count(count), .best_count(best_count),
      .best_deltaX(best_deltaX), .best_deltaY(best_deltaY), .best_beta(best_beta),
      .best_valid(best_valid)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Cycle timeline of one sweep: valid per cycle, inlier level per cycle.
   bit tl_valid [TL_N];
   bit tl_inl   [TL_N];
   int tl_len;

   // Reference record.
   int r_bv, r_best, r_bdx, r_bdy, r_bb, r_cons, r_thr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic ref_clear();
      r_bv = 0; r_best = 0; r_bdx = 0; r_bdy = 0; r_bb = 0; r_cons = 0;
   endtask

   task automatic fill_inl(input bit all_ones);
      for (int i = 0; i < TL_N; i++) tl_inl[i] = all_ones ? 1'b1 : 1'($urandom);
   endtask

   task automatic make_consec(input int n, input int k);
      tl_len = n;
      for (int i = 0; i < n; i++) begin
         tl_valid[i]    = 1'b1;
         tl_inl[i + PL] = (i < k);
      end
   endtask

   task automatic make_gapped(input int n, input int maxgap);
      int c = 0;
      for (int p = 0; p < n; p++) begin
         int gap = (p == 0) ? 0 : int'($urandom_range(0, maxgap));
         for (int g = 0; g < gap; g++) begin
            tl_valid[c] = 1'b0;
            c++;
         end
         tl_valid[c] = 1'b1;
         c++;
      end
      tl_len = c;
   endtask

   task automatic idle_inputs();
      hyp_start = 0; pt_valid = 0; pt_last = 0; inlier = 0; best_clear = 0;
   endtask

   task automatic check_record(input string tag);
      chk({tag, "_best_count"}, best_count, r_best);
      chk({tag, "_best_valid"}, best_valid, r_bv);
      chk({tag, "_best_dx"}, best_deltaX, r_bdx);
      chk({tag, "_best_dy"}, best_deltaY, r_bdy);
      chk({tag, "_best_beta"}, best_beta, r_bb);
`ifdef INLIER_ACC_CONSENSUS_EN
      chk({tag, "_consensus"}, consensus_met, r_cons);
`endif
   endtask

   task automatic run_hyp(input string tag, input int dx, input int dy, input int b,
                          input bit clr_at_cmp, input bit start_in_drain);
      int exp_cnt = 0;
      int last    = tl_len - 1;
      int pulses  = 0;
      int done_at = -1;
      logic busy0 = 1'b0;
      for (int c = 0; c < tl_len; c++) if (tl_valid[c]) exp_cnt += int'(tl_inl[c + PL]);
      if (exp_cnt > MAXP) exp_cnt = MAXP;

      @(posedge clk); #1;
      hyp_start = 1; deltaX = 9'(dx); deltaY = 9'(dy); beta = 17'(b);
      pt_valid = 1'($urandom); pt_last = 1'($urandom); inlier = 1'($urandom); best_clear = 0;
      for (int c = 0; c < tl_len + PL + 4; c++) begin
         @(posedge clk); #1;
         hyp_start  = start_in_drain && (c == last + 2);
         deltaX     = 9'($urandom); deltaY = 9'($urandom); beta = 17'($urandom);
         pt_valid   = (c < tl_len) ? tl_valid[c] : 1'($urandom);
         pt_last    = (c == last) ? 1'b1 : ((c < tl_len) ? 1'b0 : 1'($urandom));
         inlier     = tl_inl[c];
         best_clear = clr_at_cmp && (c == last + PL + 1);
         if (c == 0) busy0 = busy;
         if (hyp_done) begin
            pulses++;
            done_at = c;
         end
      end
      @(posedge clk); #1;
      idle_inputs();

      if (clr_at_cmp) ref_clear();
      if (r_bv == 0 || exp_cnt > r_best) begin
         r_bv = 1; r_best = exp_cnt; r_bdx = dx; r_bdy = dy; r_bb = b;
      end
      if (r_bv != 0 && r_best >= r_thr) r_cons = 1;

      chk({tag, "_busy_sweep"}, busy0, 1);
      chk({tag, "_done_pulses"}, pulses, 1);
      chk({tag, "_done_cycle"}, done_at, last + PL + 1);
      chk({tag, "_busy_idle"}, busy, 0);
      chk({tag, "_count"}, count, exp_cnt);
      check_record(tag);
      $display("hyp %s: pts_cycles=%0d count=%0d exp=%0d best=%0d", tag, tl_len, count, exp_cnt, best_count);
   endtask

   initial begin
      int dx, dy, b;
      r_thr = 600;
`ifdef INLIER_ACC_CONSENSUS_EN
      consensus_count = CNT_W'(r_thr);
`endif
      reset = 1; deltaX = 0; deltaY = 0; beta = 0;
      idle_inputs();
      ref_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", hyp_done, 0);
      chk("rst_count", count, 0);
      check_record("rst");
      reset = 0;
      $display("reset: busy=%0d count=%0d best_valid=%0d", busy, count, best_valid);

      // Basic count: inliers at points 0, 3, 5, 7.
      fill_inl(0);
      make_consec(8, 0);
      tl_inl[0 + PL] = 1; tl_inl[3 + PL] = 1; tl_inl[5 + PL] = 1; tl_inl[7 + PL] = 1;
      run_hyp("basic", 4, 2, 0, 0, 0);

      // Clear while idle, then 4 / 6 / 6 with tie keeping the second.
      @(posedge clk); #1; best_clear = 1;
      @(posedge clk); #1; best_clear = 0;
      ref_clear();
      chk("idle_clear_valid", best_valid, 0);
      chk("idle_clear_count", best_count, 0);
      $display("idle clear: best_valid=%0d best_count=%0d", best_valid, best_count);
      fill_inl(0); make_consec(8, 4);  run_hyp("tie_a", -7, 11, 300, 0, 0);
      fill_inl(0); make_consec(10, 6); run_hyp("tie_b", 100, -50, -1234, 0, 0);
      fill_inl(0); make_consec(9, 6);  run_hyp("tie_c", -200, 3, 65000, 0, 0);

      // Gapped valid with inlier high everywhere.
      fill_inl(1); make_gapped(5, 3);
      run_hyp("gapped", 1, 1, 1, 0, 0);

      // Reset mid-sweep: 3 points all flagged inlier, reset 2 cycles later.
      @(posedge clk); #1;
      hyp_start = 1; deltaX = 9'(55); deltaY = 9'(66); beta = 17'(77); inlier = 1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         hyp_start = 0;
         pt_valid  = (c < 3);
         reset     = (c == 5);
      end
      @(posedge clk); #1;
      reset = 0; idle_inputs();
      ref_clear();
      chk("midrst_busy", busy, 0);
      chk("midrst_count", count, 0);
      check_record("midrst");
      $display("mid-sweep reset: busy=%0d count=%0d best_valid=%0d", busy, count, best_valid);
      fill_inl(0);
      make_consec(4, 2);
      for (int i = 0; i < PL; i++) tl_inl[i] = 1'b1;
      run_hyp("post_rst", 9, 8, 7, 0, 0);

      // Clear coinciding with COMPARE, then hyp_start during DRAIN.
      fill_inl(0); make_consec(6, 5); run_hyp("pre_clr", 20, 21, 22, 0, 0);
      fill_inl(0); make_consec(3, 1); run_hyp("clr_cmp", -1, -2, -3, 1, 0);
      fill_inl(0); make_consec(6, 3); run_hyp("start_drain", 33, -33, 4444, 0, 1);

      // Randomized hypotheses.
      for (int h = 0; h < 6; h++) begin
         dx = int'($urandom_range(0, 511)) - 256;
         dy = int'($urandom_range(0, 511)) - 256;
         b  = int'($urandom_range(0, 131071)) - 65536;
         fill_inl(0);
         make_gapped(int'($urandom_range(1, 30)), 2);
         run_hyp($sformatf("rand%0d", h), dx, dy, b, ($urandom_range(0, 3) == 0), 0);
      end

      // Saturation: more inliers than the counter can hold.
      fill_inl(0); make_consec(1030, 1030);
      run_hyp("saturate", 127, -128, 65535, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
